ifu_fetch: RTL and testbench

Instruction fetch unit sitting directly upstream of the single-cycle decode/execute core. It owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready request channel, and presents each fetched word with its PC to the core over a valid/ready handoff. Branch/jump redirects from the core replace the fetch PC and squash any in-flight or held instruction.

---
 rtl/ifu_fetch.sv | 117 +++++++++++
 tb/tb_ifu_fetch.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem request in flight and
// hands each fetched word with its PC to the core; redirects squash pending work.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        inst_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        inst_err_q, inst_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inst_pc_q     <= RESET_PC;
      inst_data_q   <= NOP_INST;
      inst_err_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inst_pc_q     <= inst_pc_d;
      inst_data_q   <= inst_data_d;
      inst_err_q    <= inst_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inst_pc_d     = inst_pc_q;
    inst_data_d   = inst_data_q;
    inst_err_d    = inst_err_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      // A request accepted in the redirect cycle still carries the old address,
      // so its response must be drained before fetching the target.
      S_REQ: begin
        if (imem_req_ready) state_d = redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_OUT;
            inst_pc_d   = fetch_pc_q;
            inst_data_d = imem_resp_data;
            inst_err_d  = imem_resp_err;
          end
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
          state_d       = S_REQ;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redir_pc;
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    inst_valid     = (state_q == S_OUT);
    inst_data      = (state_q == S_OUT) ? inst_data_q : NOP_INST;
    inst_err       = (state_q == S_OUT) && inst_err_q;
  end

  assign imem_req_addr = fetch_pc_q;
  assign inst_pc       = inst_pc_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized run against a
// transaction-level model of the expected PC stream and handoff count.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // memory model controls and state
  int          mem_lat     = 0;
  logic        mem_rand    = 1'b0;
  logic        force_en    = 1'b0;
  logic [31:0] force_word  = 32'h0;
  logic        force_err   = 1'b0;
  logic        rand_err_en = 1'b0;
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr    = 32'h0;
  int          mem_cnt     = 0;
  int          acc_count   = 0;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_err       (inst_err),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: one response per accepted request, mem_cnt cycles late.
  always @(posedge clk) begin
    if (imem_resp_valid) mem_pending = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      mem_pending = 1'b1;
      mem_addr    = imem_req_addr;
      mem_cnt     = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      acc_count++;
    end else if (mem_pending && mem_cnt > 0) begin
      mem_cnt--;
    end
    #1;
    imem_resp_valid = mem_pending && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? (force_en ? force_word : word_of(mem_addr)) : $urandom;
    imem_resp_err   = imem_resp_valid && (force_err || (rand_err_en && mem_addr[4:2] == 3'd5));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    mem_lat        = 0;
    mem_rand       = 1'b0;
    force_en       = 1'b0;
    force_err      = 1'b0;
    rand_err_en    = 1'b0;
  endtask

  // Ends at the first negedge with the DUT presenting its first request.
  task automatic do_reset();
    set_idle_inputs();
    rst = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || inst_valid !== 1'b0 ||
        inst_pc !== RST_PC || inst_data !== NOP || inst_err !== 1'b0 || fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: req_valid=%b addr=%h inst_valid=%b pc=%h data=%h err=%b count=%0d",
               imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err, fetch_count);
    end
    rst = 1'b1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: req_valid=%b required 0", imem_req_valid);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_first_req: req_valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] pc;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    for (int k = 0; k < 9; k++) begin
      pc = RST_PC + 32'(4 * (k / 3));
      checks++;
      if (imem_req_valid !== (k % 3 == 0) || inst_valid !== (k % 3 == 2)) begin
        errors++;
        $display("FAIL zero_wait_cycle%0d: req_valid=%b inst_valid=%b required %b %b",
                 k, imem_req_valid, inst_valid, (k % 3 == 0), (k % 3 == 2));
      end
      if (k % 3 == 0) begin
        checks++;
        if (imem_req_addr !== pc) begin
          errors++;
          $display("FAIL zero_wait_addr%0d: got %h required %h", k, imem_req_addr, pc);
        end
      end
      if (k % 3 == 2) begin
        checks++;
        if (inst_pc !== pc || inst_data !== word_of(pc)) begin
          errors++;
          $display("FAIL zero_wait_inst%0d: pc=%h data=%h required %h %h", k, inst_pc, inst_data, pc, word_of(pc));
        end
      end
      tick();
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL zero_wait_count: got %0d required 3", fetch_count);
    end
    set_idle_inputs();
  endtask

  task automatic test_stall();
    int acc0;
    do_reset();
    acc0 = acc_count;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
        errors++;
        $display("FAIL stall_req%0d: valid=%b addr=%h required 1 %h", i, imem_req_valid, imem_req_addr, RST_PC);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst_data !== word_of(RST_PC) ||
          imem_req_valid !== 1'b0 || fetch_count !== 32'd0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h data=%h req=%b count=%0d required 1 %h %h 0 0",
                 j, inst_valid, inst_pc, inst_data, imem_req_valid, fetch_count, RST_PC, word_of(RST_PC));
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (fetch_count !== 32'd1 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'd4 ||
        inst_valid !== 1'b0 || inst_data !== NOP) begin
      errors++;
      $display("FAIL stall_release: count=%0d req=%b addr=%h valid=%b data=%h required 1 1 %h 0 %h",
               fetch_count, imem_req_valid, imem_req_addr, inst_valid, inst_data, RST_PC + 32'd4, NOP);
    end
    checks++;
    if (acc_count - acc0 !== 1) begin
      errors++;
      $display("FAIL stall_dup_req: accepted=%0d required 1", acc_count - acc0);
    end
    set_idle_inputs();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat        = 3;
    force_en       = 1'b1;
    force_word     = 32'hDEAD_BEEF;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data === 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL redir_wait_drain%0d: req=%b valid=%b data=%h required 0 0 not-deadbeef",
                 i, imem_req_valid, inst_valid, inst_data);
      end
      tick();
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_req: req=%b addr=%h valid=%b required 1 80000100 0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
    force_en       = 1'b0;
    mem_lat        = 0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100 || inst_data !== word_of(32'h8000_0100)) begin
      errors++;
      $display("FAIL redir_wait_inst: valid=%b pc=%h data=%h required 1 80000100 %h",
               inst_valid, inst_pc, inst_data, word_of(32'h8000_0100));
    end
    set_idle_inputs();
  endtask

  task automatic test_redirect_handoff();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
      errors++;
      $display("FAIL redir_req_stall: req=%b addr=%h required 1 80000010", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0010) begin
      errors++;
      $display("FAIL redir_handoff_inst: valid=%b pc=%h required 1 80000010", inst_valid, inst_pc);
    end
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0240;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    checks++;
    if (fetch_count !== 32'd0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0240 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_handoff: count=%0d req=%b addr=%h valid=%b required 0 1 80000240 0",
               fetch_count, imem_req_valid, imem_req_addr, inst_valid);
    end
    set_idle_inputs();
  endtask

  task automatic test_err();
    do_reset();
    force_err      = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_err !== 1'b1 || inst_data !== word_of(RST_PC)) begin
      errors++;
      $display("FAIL err_flag: valid=%b err=%b data=%h required 1 1 %h", inst_valid, inst_err, inst_data, word_of(RST_PC));
    end
    force_err      = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    checks++;
    if (fetch_count !== 32'd1 || imem_req_addr !== RST_PC + 32'd4 || inst_err !== 1'b0) begin
      errors++;
      $display("FAIL err_next_req: count=%0d addr=%h err=%b required 1 %h 0", fetch_count, imem_req_addr, inst_err, RST_PC + 32'd4);
    end
    inst_ready = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 32'd4 || inst_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: valid=%b pc=%h err=%b required 1 %h 0", inst_valid, inst_pc, inst_err, RST_PC + 32'd4);
    end
    set_idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_align: addr=%h required fffffffc", imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || fetch_count !== 32'd1) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h count=%0d required 1 00000000 1", imem_req_valid, imem_req_addr, fetch_count);
    end
    set_idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_lat        = 3;
    force_en       = 1'b1;
    force_word     = 32'hDEAD_BEEF;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC || inst_valid !== 1'b0 ||
        inst_pc !== RST_PC || inst_data !== NOP || inst_err !== 1'b0 || fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_now: req=%b addr=%h valid=%b pc=%h data=%h err=%b count=%0d",
               imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err, fetch_count);
    end
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_late_resp: req=%b addr=%h valid=%b required 1 %h 0",
               imem_req_valid, imem_req_addr, inst_valid, RST_PC);
    end
    force_en       = 1'b0;
    mem_lat        = 0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst_data !== word_of(RST_PC)) begin
      errors++;
      $display("FAIL async_reset_refetch: valid=%b pc=%h data=%h required 1 %h %h",
               inst_valid, inst_pc, inst_data, RST_PC, word_of(RST_PC));
    end
    set_idle_inputs();
  endtask

  // Model: the core sees a stream of PCs starting at RESET_PC, stepping by 4 on
  // each accepted handoff and restarting at the aligned target on redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic        exp_err;
    int          since;
    do_reset();
    mem_rand    = 1'b1;
    rand_err_en = 1'b1;
    exp_pc      = RST_PC;
    exp_count   = 32'd0;
    since       = 0;
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (imem_req_valid && mem_pending) begin
        errors++;
        $display("FAIL rand_outstanding c%0d: req_valid=1 while a response is pending, required 0", c);
      end
      checks++;
      if (fetch_count !== exp_count) begin
        errors++;
        $display("FAIL rand_count c%0d: got %0d required %0d", c, fetch_count, exp_count);
      end
      exp_err = (exp_pc[4:2] == 3'd5);
      checks++;
      if (inst_valid) begin
        if (inst_pc !== exp_pc || inst_data !== word_of(exp_pc) || inst_err !== exp_err) begin
          errors++;
          $display("FAIL rand_inst c%0d: pc=%h data=%h err=%b required %h %h %b",
                   c, inst_pc, inst_data, inst_err, exp_pc, word_of(exp_pc), exp_err);
        end
      end else if (inst_data !== NOP || inst_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle_out c%0d: data=%h err=%b required %h 0", c, inst_data, inst_err, NOP);
      end
      imem_req_ready = ($urandom_range(0, 9) < 7);
      inst_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom;
      if (imem_req_valid && imem_req_ready && !redirect_valid) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin
          errors++;
          $display("FAIL rand_req_addr c%0d: got %h required %h", c, imem_req_addr, exp_pc);
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (inst_valid && inst_ready) begin
        exp_pc    = exp_pc + 32'd4;
        exp_count = exp_count + 32'd1;
        since     = 0;
      end
      since++;
      if (since > 100) begin
        errors++;
        $display("FAIL rand_progress c%0d: no handoff for %0d cycles, required at most 100", c, since);
        break;
      end
      tick();
    end
    set_idle_inputs();
  endtask

  initial begin
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    set_idle_inputs();
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_handoff();
    test_err();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
